dmem_responder: RTL

- Multicycle data-memory responder: the memory-side end of the CPU's rdMem/wrMem request interface.
- Accepts one load or store request at a time and inserts a configurable number of wait states.
- Returns a one-cycle response pulse carrying read data or an error flag.
- Sits between the multicycle FSM core's datapath memory port and a word-addressed synchronous RAM. The FSM core stalls in its execute phase until resp_valid.

---
 rtl/dmem_resp_pkg.sv | 24 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e    : responder FSM states
//   WORD_BYTES : bytes per RAM word; WORD_OFFS is the byte-offset width
//   addr_err() : flags misaligned or out-of-range byte addresses
package dmem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_OFFS  = $clog2(WORD_BYTES);

   // An address is bad if it is not word aligned, or if any bit above the
   // word index is set (the RAM holds 2^addr_w words).
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
      logic [31:0] hi;
      hi = addr >> (addr_w + WORD_OFFS);
      return (addr[WORD_OFFS-1:0] != '0) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM, 2^ADDR_W x 32.
//   clk_i              : write clock
//   we_a_i/addr_a_i    : port A synchronous write enable / word index
//   wdata_a_i          : port A write data
//   rdata_a_o          : port A asynchronous read data
//   addr_b_i/rdata_b_o : port B asynchronous read (debug readout)
// Contents are deliberately not reset.
module dmem_array #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              we_a_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [31:0]       wdata_a_i,
   output logic [31:0]       rdata_a_o,
   input  logic [ADDR_W-1:0] addr_b_i,
   output logic [31:0]       rdata_b_o
);

   localparam int unsigned Depth = 1 << ADDR_W;

   logic [31:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_a_i) begin
         mem_q[addr_a_i] <= wdata_a_i;
      end
   end

   assign rdata_a_o = mem_q[addr_a_i];
   assign rdata_b_o = mem_q[addr_b_i];

endmodule

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES states, commits to the RAM, then pulses resp_valid for one cycle.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/req_we  : request strobe, 1 = store
//   req_addr/req_wdata: byte address, store data (sampled at accept only)
//   req_ready, busy   : idle / request in flight
//   resp_valid        : one-cycle completion pulse
//   resp_rdata/err    : load data / access error, meaningful with resp_valid
//   dbg_addr/dbg_data : asynchronous debug read of a RAM word
module dmem_responder
   import dmem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_data
);

   localparam bit          NoWait  = (WAIT_CYCLES == 0);
   localparam logic [3:0]  CntInit = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic              commit;
   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic              cur_err;
   logic [ADDR_W-1:0] cur_idx;
   logic              mem_we;
   logic [31:0]       mem_rdata;

   // With no wait states the commit happens on the accept edge itself, so the
   // commit path must look at the live request rather than the latched copy.
   assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
   assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign cur_err   = addr_err(cur_addr, ADDR_W);
   assign cur_idx   = cur_addr[ADDR_W+WORD_OFFS-1:WORD_OFFS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (NoWait) begin
                  commit  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = CntInit;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = cur_err;
         rdata_d = (cur_we || cur_err) ? 32'd0 : mem_rdata;
      end
   end

   // Reset must suppress the write even on what would have been a commit edge.
   assign mem_we = commit && cur_we && !cur_err && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i     (clk),
      .we_a_i    (mem_we),
      .addr_a_i  (cur_idx),
      .wdata_a_i (cur_wdata),
      .rdata_a_o (mem_rdata),
      .addr_b_i  (dbg_addr),
      .rdata_b_o (dbg_data)
   );

   assign req_ready  = (state_q == IDLE);
   assign busy       = !req_ready;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
